// File: rtl/miner_slave_regs_pkg.sv
// Shared constants, state encoding and address helpers for the miner slave register bank.
package miner_pkg;

    localparam logic [4:0] ADDR_CTRL    = 5'd0;
    localparam logic [4:0] ADDR_IRQ     = 5'd1;
    localparam logic [4:0] ADDR_MSG_LO  = 5'd3;
    localparam logic [4:0] ADDR_MSG_HI  = 5'd15;
    localparam logic [4:0] ADDR_TGT_LO  = 5'd16;
    localparam logic [4:0] ADDR_TGT_HI  = 5'd23;
    localparam logic [4:0] ADDR_HASH_LO = 5'd24;
    localparam logic [4:0] ADDR_HASH_HI = 5'd31;

    localparam int CTRL_LOAD_TGT  = 0;
    localparam int CTRL_LOAD_MSG  = 1;
    localparam int CTRL_CLR_FOUND = 2;

    localparam int MSG_W = 408;
    localparam int TGT_W = 256;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_PEND = 2'd1,
        CMD_FIRE = 2'd2
    } cmd_state_t;

    // Address 4 maps to msg[55:24]; address 3 holds only the low 24 bits.
    function automatic int msg_word_lsb(input logic [4:0] a);
        return ((int'(a) - 4) * 32) + 24;
    endfunction

    function automatic int tgt_word_lsb(input logic [4:0] a);
        return (int'(a) - 16) * 32;
    endfunction

    function automatic int hash_word_lsb(input logic [4:0] a);
        return (int'(a) - 24) * 32;
    endfunction

endpackage

// File: rtl/miner_slave_regs_if.sv
// Avalon-MM slave bus bundle between the host bridge and the miner register bank.
interface miner_slave_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] slaveAddr;
    logic [DATA_W-1:0] slaveWriteData;
    logic              slaveWrite;
    logic              slaveRead;
    logic              slaveChipSelect;
    logic [DATA_W-1:0] slaveReadData;

    modport master (
        output slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
        input  slaveReadData
    );

    modport slave (
        input  slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
        output slaveReadData
    );
endinterface

// File: rtl/miner_slave_regs_cmd_fsm.sv
// Load-command sequencer: merges LOAD_TARGET/LOAD_MSG requests, waits for the core
// to go idle, then issues copy enables and registered one-cycle pulses.
module miner_cmd_fsm
    import miner_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_wr_i,
    input  logic [1:0] load_cmd_i,
    input  logic       core_busy_i,
    output logic       copy_tgt_o,
    output logic       copy_msg_o,
    output logic       new_tgt_o,
    output logic       new_msg_o,
    output logic       pending_o,
    output logic       active_o
);

    cmd_state_t state_q, state_d;
    logic [1:0] pend_cmd_q, pend_cmd_d;
    logic       new_tgt_q, new_tgt_d;
    logic       new_msg_q, new_msg_d;
    logic [1:0] req_s;
    logic [1:0] copy_s;

    // A request arriving on the transfer edge rides along with the pending one.
    always_comb begin
        req_s      = ctrl_wr_i ? load_cmd_i : 2'b00;
        state_d    = state_q;
        pend_cmd_d = pend_cmd_q;
        copy_s     = 2'b00;
        case (state_q)
            CMD_IDLE: begin
                if (req_s != 2'b00) begin
                    pend_cmd_d = req_s;
                    state_d    = CMD_PEND;
                end else begin
                    pend_cmd_d = 2'b00;
                end
            end
            CMD_PEND: begin
                if (!core_busy_i) begin
                    copy_s     = pend_cmd_q | req_s;
                    pend_cmd_d = 2'b00;
                    state_d    = CMD_FIRE;
                end else begin
                    pend_cmd_d = pend_cmd_q | req_s;
                end
            end
            CMD_FIRE: begin
                pend_cmd_d = pend_cmd_q | req_s;
                if ((pend_cmd_q | req_s) != 2'b00) begin
                    state_d = CMD_PEND;
                end else begin
                    state_d = CMD_IDLE;
                end
            end
            default: begin
                state_d    = CMD_IDLE;
                pend_cmd_d = 2'b00;
            end
        endcase
        new_tgt_d = copy_s[CTRL_LOAD_TGT];
        new_msg_d = copy_s[CTRL_LOAD_MSG];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CMD_IDLE;
            pend_cmd_q <= 2'b00;
            new_tgt_q  <= 1'b0;
            new_msg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_cmd_q <= pend_cmd_d;
            new_tgt_q  <= new_tgt_d;
            new_msg_q  <= new_msg_d;
        end
    end

    assign copy_tgt_o = copy_s[CTRL_LOAD_TGT];
    assign copy_msg_o = copy_s[CTRL_LOAD_MSG];
    assign new_tgt_o  = new_tgt_q;
    assign new_msg_o  = new_msg_q;
    assign pending_o  = (state_q == CMD_PEND);
    assign active_o   = (state_q != CMD_IDLE);

endmodule

// File: rtl/miner_slave_regs.sv
// Avalon-MM register bank feeding the miner core: staging/active message and target,
// result capture and status. Optional MINER_IRQ_EN adds an irq output and enable register.
module miner_slave_regs
    import miner_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    miner_slave_regs_if.slave bus,
    output logic [MSG_W-1:0] inputMsg,
    output logic [TGT_W-1:0] inputTarget,
    output logic             newMsg,
    output logic             newTarget,
    input  logic             coreBusy,
    input  logic             coreDone,
    input  logic             validBTC,
`ifdef MINER_IRQ_EN
    output logic             irq,
`endif
    input  logic [TGT_W-1:0] SHAoutput
);

    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              wr_s, rd_s, ctrl_wr_s;
    logic              copy_tgt_s, copy_msg_s, pending_s, active_s, busy_s;
    logic              found_set_s, found_clr_s;

    logic [MSG_W-1:0]  msg_stage_q, msg_stage_d;
    logic [TGT_W-1:0]  tgt_stage_q, tgt_stage_d;
    logic [MSG_W-1:0]  msg_act_q;
    logic [TGT_W-1:0]  tgt_act_q;
    logic [TGT_W-1:0]  hash_q;
    logic              found_q, found_d;
    logic [DATA_W-1:0] rd_q, rd_word_s;

    assign addr_s    = bus.slaveAddr;
    assign wdata_s   = bus.slaveWriteData;
    assign wr_s      = bus.slaveChipSelect & bus.slaveWrite;
    assign rd_s      = bus.slaveChipSelect & bus.slaveRead;
    assign ctrl_wr_s = wr_s && (addr_s == ADDR_CTRL);
    assign busy_s    = coreBusy | active_s;

    miner_cmd_fsm u_cmd_fsm (
        .clk         (clk),
        .rst         (rst),
        .ctrl_wr_i   (ctrl_wr_s),
        .load_cmd_i  (wdata_s[1:0]),
        .core_busy_i (coreBusy),
        .copy_tgt_o  (copy_tgt_s),
        .copy_msg_o  (copy_msg_s),
        .new_tgt_o   (newTarget),
        .new_msg_o   (newMsg),
        .pending_o   (pending_s),
        .active_o    (active_s)
    );

    // Staging writes; read-only and reserved addresses fall through untouched.
    always_comb begin
        msg_stage_d = msg_stage_q;
        tgt_stage_d = tgt_stage_q;
        if (wr_s) begin
            if (addr_s == ADDR_MSG_LO) begin
                msg_stage_d[23:0] = wdata_s[31:8];
            end else if ((addr_s > ADDR_MSG_LO) && (addr_s <= ADDR_MSG_HI)) begin
                msg_stage_d[msg_word_lsb(addr_s) +: 32] = wdata_s;
            end else if ((addr_s >= ADDR_TGT_LO) && (addr_s <= ADDR_TGT_HI)) begin
                tgt_stage_d[tgt_word_lsb(addr_s) +: 32] = wdata_s;
            end else begin
                msg_stage_d = msg_stage_q;
            end
        end else begin
            tgt_stage_d = tgt_stage_q;
        end
    end

    assign found_set_s = coreDone & validBTC;
    assign found_clr_s = (ctrl_wr_s & wdata_s[CTRL_CLR_FOUND]) | copy_msg_s;

    always_comb begin
        found_d = found_q;
        if (found_set_s) begin
            found_d = 1'b1;
        end else if (found_clr_s) begin
            found_d = 1'b0;
        end else begin
            found_d = found_q;
        end
    end

`ifdef MINER_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_s && (addr_s == ADDR_IRQ)) begin
                irq_en_q <= wdata_s[0];
            end else begin
                irq_en_q <= irq_en_q;
            end
            irq_q <= found_q & irq_en_q;
        end
    end

    assign irq = irq_q;
`endif

    // Read mux works on pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        if (addr_s == ADDR_CTRL) begin
            rd_word_s = {29'd0, found_q, pending_s, busy_s};
`ifdef MINER_IRQ_EN
        end else if (addr_s == ADDR_IRQ) begin
            rd_word_s = {31'd0, irq_en_q};
`endif
        end else if (addr_s < ADDR_MSG_LO) begin
            rd_word_s = {DATA_W{1'b0}};
        end else if (addr_s == ADDR_MSG_LO) begin
            rd_word_s = {msg_stage_q[23:0], 8'd0};
        end else if (addr_s <= ADDR_MSG_HI) begin
            rd_word_s = msg_stage_q[msg_word_lsb(addr_s) +: 32];
        end else if (addr_s <= ADDR_TGT_HI) begin
            rd_word_s = tgt_stage_q[tgt_word_lsb(addr_s) +: 32];
        end else begin
            rd_word_s = hash_q[hash_word_lsb(addr_s) +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_stage_q <= {MSG_W{1'b0}};
            tgt_stage_q <= {TGT_W{1'b0}};
            msg_act_q   <= {MSG_W{1'b0}};
            tgt_act_q   <= {TGT_W{1'b0}};
            hash_q      <= {TGT_W{1'b0}};
            found_q     <= 1'b0;
            rd_q        <= {DATA_W{1'b0}};
        end else begin
            msg_stage_q <= msg_stage_d;
            tgt_stage_q <= tgt_stage_d;
            found_q     <= found_d;
            if (copy_msg_s) begin
                msg_act_q <= msg_stage_q;
            end else begin
                msg_act_q <= msg_act_q;
            end
            if (copy_tgt_s) begin
                tgt_act_q <= tgt_stage_q;
            end else begin
                tgt_act_q <= tgt_act_q;
            end
            if (coreDone) begin
                hash_q <= SHAoutput;
            end else begin
                hash_q <= hash_q;
            end
            if (rd_s) begin
                rd_q <= rd_word_s;
            end else begin
                rd_q <= rd_q;
            end
        end
    end

    assign inputMsg          = msg_act_q;
    assign inputTarget       = tgt_act_q;
    assign bus.slaveReadData = rd_q;

endmodule

// File: tb/tb_miner_slave_regs.sv
// Directed self-checking bench for miner_slave_regs (default build, no irq port).
module tb_miner_slave_regs;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [407:0] inputMsg;
    logic [255:0] inputTarget;
    logic         newMsg, newTarget;
    logic         coreBusy = 1'b0;
    logic         coreDone = 1'b0;
    logic         validBTC = 1'b0;
    logic [255:0] SHAoutput = 256'd0;

    int tests_run    = 0;
    int tests_failed = 0;
    int msg_pulses   = 0;
    int tgt_pulses   = 0;

    always #5 clk = ~clk;

    miner_slave_regs_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();

    miner_slave_regs #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .inputMsg    (inputMsg),
        .inputTarget (inputTarget),
        .newMsg      (newMsg),
        .newTarget   (newTarget),
        .coreBusy    (coreBusy),
        .coreDone    (coreDone),
        .validBTC    (validBTC),
        .SHAoutput   (SHAoutput)
    );

    always @(negedge clk) begin
        if (newMsg)    msg_pulses++;
        if (newTarget) tgt_pulses++;
    end

    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge clk);
        bus_if.slaveAddr       = 5'(a);
        bus_if.slaveWriteData  = d;
        bus_if.slaveWrite      = 1'b1;
        bus_if.slaveChipSelect = 1'b1;
        @(negedge clk);
        bus_if.slaveWrite      = 1'b0;
        bus_if.slaveChipSelect = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        @(negedge clk);
        bus_if.slaveAddr       = 5'(a);
        bus_if.slaveRead       = 1'b1;
        bus_if.slaveChipSelect = 1'b1;
        @(negedge clk);
        bus_if.slaveRead       = 1'b0;
        bus_if.slaveChipSelect = 1'b0;
        d = bus_if.slaveReadData;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int m0, t0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({newMsg, newTarget} !== 2'b00 || inputMsg !== 408'd0 || inputTarget !== 256'd0
            || bus_if.slaveReadData !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: newMsg=%b newTarget=%b rdata=%h, required all zero",
                     newMsg, newTarget, bus_if.slaveReadData);
        end
        coreBusy = 1'b1;
        bus_write(23, 32'h12345678);
        bus_write(0, 32'd3);
        m0 = msg_pulses;
        t0 = tgt_pulses;
        @(negedge clk);
        rst = 1'b1;
        coreBusy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (msg_pulses != m0 || tgt_pulses != t0) begin
            tests_failed++;
            $display("FAIL reset_abort_pulses: msg=%0d tgt=%0d extra pulses, required 0",
                     msg_pulses - m0, tgt_pulses - t0);
        end
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status: got %h, required 00000000", rd);
        end
        bus_read(23, rd);
        tests_run++;
        if (rd !== 32'h0 || inputMsg !== 408'd0 || inputTarget !== 256'd0) begin
            tests_failed++;
            $display("FAIL reset_staging: addr23=%h, required 00000000 and zero actives", rd);
        end
    endtask

    task automatic test_target_load();
        int m0, t0;
        bus_write(23, 32'h0FFFFFFF);
        for (int a = 22; a >= 16; a--) bus_write(a, 32'hFFFFFFFF);
        m0 = msg_pulses;
        t0 = tgt_pulses;
        bus_write(0, 32'd1);
        tests_run++;
        if (newTarget !== 1'b0) begin
            tests_failed++;
            $display("FAIL tgt_early: newTarget=%b one cycle after CTRL, required 0", newTarget);
        end
        @(negedge clk);
        tests_run++;
        if (newTarget !== 1'b1 || newMsg !== 1'b0 || inputTarget !== {32'h0FFFFFFF, {224{1'b1}}}) begin
            tests_failed++;
            $display("FAIL tgt_load: newTarget=%b newMsg=%b tgt_hi=%h, required 1 0 0fffffff",
                     newTarget, newMsg, inputTarget[255:224]);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (newTarget !== 1'b0 || tgt_pulses - t0 != 1 || msg_pulses - m0 != 0) begin
            tests_failed++;
            $display("FAIL tgt_pulse_width: tgt=%0d msg=%0d pulses, required 1 and 0",
                     tgt_pulses - t0, msg_pulses - m0);
        end
    endtask

    task automatic test_msg_load();
        int m0;
        bus_write(15, 32'h00000061);
        m0 = msg_pulses;
        bus_write(0, 32'd2);
        @(negedge clk);
        tests_run++;
        if (newMsg !== 1'b1 || inputMsg !== {32'h00000061, 376'd0}) begin
            tests_failed++;
            $display("FAIL msg_load: newMsg=%b msg_hi=%h, required 1 00000061",
                     newMsg, inputMsg[407:376]);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (msg_pulses - m0 != 1) begin
            tests_failed++;
            $display("FAIL msg_pulse_count: %0d, required 1", msg_pulses - m0);
        end
    endtask

    task automatic test_busy_defer();
        logic [31:0] rd;
        int m0;
        @(negedge clk);
        coreBusy = 1'b1;
        m0 = msg_pulses;
        bus_write(0, 32'd2);
        bus_write(15, 32'hDEADBEEF);
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++;
            $display("FAIL busy_status: got %h, required 00000003", rd);
        end
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (msg_pulses != m0 || newMsg !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_no_pulse: %0d pulses while busy, required 0", msg_pulses - m0);
        end
        coreBusy = 1'b0;
        @(negedge clk);
        tests_run++;
        if (newMsg !== 1'b1 || inputMsg[407:376] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL busy_release: newMsg=%b msg_hi=%h, required 1 deadbeef",
                     newMsg, inputMsg[407:376]);
        end
    endtask

    task automatic test_both_loads();
        logic [31:0] rd;
        bus_write(3, 32'hAABBCCDD);
        bus_write(0, 32'd3);
        @(negedge clk);
        tests_run++;
        if ({newMsg, newTarget} !== 2'b11 || inputMsg[23:0] !== 24'hAABBCC
            || inputMsg[407:376] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL both_load: pulses=%b msg_lo=%h msg_hi=%h, required 11 aabbcc deadbeef",
                     {newMsg, newTarget}, inputMsg[23:0], inputMsg[407:376]);
        end
        bus_read(3, rd);
        tests_run++;
        if (rd !== 32'hAABBCC00) begin
            tests_failed++;
            $display("FAIL addr3_read: got %h, required aabbcc00", rd);
        end
    endtask

    task automatic test_result();
        logic [31:0] rd;
        @(negedge clk);
        coreDone = 1'b1; validBTC = 1'b1; SHAoutput = {32'h00000ABC, 224'd0};
        @(negedge clk);
        coreDone = 1'b0; validBTC = 1'b0;
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL found_set: status %h, required 00000004", rd);
        end
        bus_read(31, rd);
        tests_run++;
        if (rd !== 32'h00000ABC) begin
            tests_failed++;
            $display("FAIL hash_read: got %h, required 00000abc", rd);
        end
        @(negedge clk);
        coreDone = 1'b1; validBTC = 1'b1;
        bus_if.slaveAddr = 5'd0; bus_if.slaveWriteData = 32'd4;
        bus_if.slaveWrite = 1'b1; bus_if.slaveChipSelect = 1'b1;
        @(negedge clk);
        coreDone = 1'b0; validBTC = 1'b0;
        bus_if.slaveWrite = 1'b0; bus_if.slaveChipSelect = 1'b0;
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL set_beats_clear: status %h, required 00000004", rd);
        end
        bus_write(0, 32'd4);
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL clr_found: status %h, required 00000000", rd);
        end
        @(negedge clk);
        coreDone = 1'b1; validBTC = 1'b1;
        @(negedge clk);
        coreDone = 1'b0; validBTC = 1'b0;
        bus_write(0, 32'd2);
        repeat (2) @(negedge clk);
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL load_msg_clears_found: status %h, required 00000000", rd);
        end
        @(negedge clk);
        coreDone = 1'b1; validBTC = 1'b0; SHAoutput = {32'h00000055, 224'd0};
        @(negedge clk);
        coreDone = 1'b0;
        bus_read(31, rd);
        tests_run++;
        if (rd !== 32'h00000055) begin
            tests_failed++;
            $display("FAIL hash_no_found: addr31 %h, required 00000055", rd);
        end
        bus_read(0, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL invalid_no_found: status %h, required 00000000", rd);
        end
    endtask

    task automatic test_bus_rules();
        logic [31:0] rd;
        @(negedge clk);
        bus_if.slaveAddr = 5'd16; bus_if.slaveWriteData = 32'h11111111;
        bus_if.slaveWrite = 1'b1; bus_if.slaveChipSelect = 1'b0;
        @(negedge clk);
        bus_if.slaveWrite = 1'b0;
        bus_read(16, rd);
        tests_run++;
        if (rd !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL cs_low_write: addr16 %h, required ffffffff", rd);
        end
        bus_write(1, 32'hFFFFFFFF);
        bus_write(2, 32'hFFFFFFFF);
        bus_write(24, 32'hFFFFFFFF);
        bus_read(1, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reserved1: got %h, required 00000000", rd);
        end
        bus_read(2, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reserved2: got %h, required 00000000", rd);
        end
        bus_read(24, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL hash_ro: got %h, required 00000000", rd);
        end
        @(negedge clk);
        bus_if.slaveAddr = 5'd16; bus_if.slaveWriteData = 32'h22222222;
        bus_if.slaveWrite = 1'b1; bus_if.slaveRead = 1'b1; bus_if.slaveChipSelect = 1'b1;
        @(negedge clk);
        bus_if.slaveWrite = 1'b0; bus_if.slaveRead = 1'b0; bus_if.slaveChipSelect = 1'b0;
        tests_run++;
        if (bus_if.slaveReadData !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL rw_same_cycle: got %h, required ffffffff", bus_if.slaveReadData);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_if.slaveReadData !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL read_hold: got %h, required ffffffff", bus_if.slaveReadData);
        end
        bus_read(16, rd);
        tests_run++;
        if (rd !== 32'h22222222) begin
            tests_failed++;
            $display("FAIL rw_write_effect: got %h, required 22222222", rd);
        end
    endtask

    initial begin
        bus_if.slaveAddr       = 5'd0;
        bus_if.slaveWriteData  = 32'd0;
        bus_if.slaveWrite      = 1'b0;
        bus_if.slaveRead       = 1'b0;
        bus_if.slaveChipSelect = 1'b0;
        test_reset();
        test_target_load();
        test_msg_load();
        test_busy_defer();
        test_both_loads();
        test_result();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/miner_slave_regs.md
# miner_slave_regs

Avalon-MM slave register bank that sits directly upstream of the miner core. It collects 32-bit bus writes into staging registers for the 408-bit block-header message and the 256-bit target. On a control command it transfers them into the core's input registers with one-cycle `newMsg`/`newTarget` pulses, deferring the transfer while the core is busy. It also latches the core's hash and result and makes both readable on the bus.

## Interface
- `DATA_W`, 32: bus data width; only 32 is supported.
- `ADDR_W`, 5: bus word-address width; only 5 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `slaveAddr`  in  5  word address.
- `slaveWriteData`  in  32  write data.
- `slaveWrite`  in  1  write strobe, qualified by `slaveChipSelect`.
- `slaveRead`  in  1  read strobe, qualified by `slaveChipSelect`.
- `slaveChipSelect`  in  1  slave select.
- `slaveReadData`  out  32  registered read data.
- `inputMsg`  out  408  active message to the core.
- `inputTarget`  out  256  active target to the core.
- `newMsg`  out  1  one-cycle pulse; `inputMsg` updated in the same cycle.
- `newTarget`  out  1  one-cycle pulse; `inputTarget` updated in the same cycle.
- `coreBusy`  in  1  core is hashing; loads are deferred while high.
- `coreDone`  in  1  one-cycle pulse at the end of a hash.
- `validBTC`  in  1  hash ≤ target; sampled only with `coreDone`.
- `SHAoutput`  in  256  hash; sampled only with `coreDone`.

## Operation
- Address map:
  - 0 = CTRL/STATUS.
  - 1–2 = reserved: read 0, writes ignored.
  - 3–15 = message staging: addr 15 = msg[407:376], down to addr 4 = msg[55:24]; addr 3 bits[31:8] = msg[23:0], bits[7:0] discarded.
  - 16–23 = target staging: addr 23 = tgt[255:224], down to addr 16 = tgt[31:0].
  - 24–31 = latched hash, read-only: addr 31 = hash[255:224].
- CTRL write bits:
  - bit0 LOAD_TARGET.
  - bit1 LOAD_MSG.
  - bit2 CLR_FOUND.
  - Other bits ignored.
- STATUS read: {29'b0, found, pending, busy}.
  - busy = `coreBusy` | (state ≠ IDLE).
  - pending = state == PEND.
- Command FSM, states IDLE, PEND, FIRE:
  - IDLE: a CTRL write with bit0 or bit1 set ORs those bits into `pend_cmd` and moves to PEND.
  - PEND: when `coreBusy` is sampled low, copy staging to active for each set `pend_cmd` bit, register the matching pulse(s), clear `pend_cmd`, and go to FIRE. Otherwise stay.
  - FIRE: lasts one cycle; pulses are high. Then go to IDLE.
  - A load command arriving in PEND or FIRE is OR-merged into `pend_cmd`. From FIRE, a merged command goes to PEND instead of IDLE.
  - The payload transferred is the staging content at the transfer edge. Staging writes during PEND are therefore included.
  - Both load bits set: both pulses fire in the same cycle.
- Result capture on `coreDone`:
  - The hash shadow always loads `SHAoutput`.
  - found is set if `validBTC`.
- Clearing found:
  - CLR_FOUND clears found.
  - A LOAD_MSG transfer also clears found.
  - Simultaneous set and clear: set wins.
- Bus access rules:
  - Writes and reads with `slaveChipSelect` low are ignored.
  - Writes to read-only or reserved addresses are ignored.
  - Read and write in the same cycle: the write takes effect and the read returns the pre-write value.

## Timing
- Reset state: all staging, active, hash, `pend_cmd`, found, `slaveReadData`, `newMsg` and `newTarget` are 0; FSM in IDLE.
- Reset mid-operation aborts any pending load. No pulse is emitted.
- Load latency:
  - CTRL write accepted at edge E0 → PEND after E0.
  - If `coreBusy` is low at E1, pulse and payload are registered at E1 and are high for exactly the cycle E1–E2.
  - Each additional busy cycle adds one cycle of latency.
- Read latency: `slaveReadData` is valid the cycle after the read is sampled and holds until the next read.
- Found visibility: found is readable in STATUS on a read issued the cycle after `coreDone`.

## Configuration
- `MINER_IRQ_EN` defined:
  - Adds port `irq` out 1 (after `validBTC`).
  - Addr 1 bit0 = IRQ_EN, read/write, reset 0.
  - `irq` is registered found & IRQ_EN; it deasserts the cycle after found clears.
- `MINER_IRQ_EN` undefined: no `irq` port; addr 1 behaves as reserved.

## Structure
- Package `miner_pkg` holds:
  - Address constants: ADDR_CTRL, ADDR_IRQ, ADDR_MSG_LO/HI, ADDR_TGT_LO/HI, ADDR_HASH_LO/HI.
  - CTRL bit indices.
  - MSG_W = 408, TGT_W = 256.
  - The FSM state enum `cmd_state_t`.
- One sub-module, `miner_cmd_fsm`: implements IDLE/PEND/FIRE, `pend_cmd` merging and pulse generation. It outputs copy enables to the register bank.

## Test plan
- Reset asserted mid-PEND → pulses never assert; read addr 0 returns 0x00000000; all outputs 0.
- Target writes addr 23 = 0x0FFFFFFF, addr 22–16 = 0xFFFFFFFF, then CTRL = 1 with `coreBusy` = 0 → `newTarget` high for exactly 1 cycle, 2 cycles after the CTRL write; `inputTarget` = 256'h0FFF…F; `newMsg` stays 0.
- Addr 15 = 0x00000061, CTRL = 2 → `inputMsg`[407:376] = 0x00000061, rest 0; one `newMsg` pulse.
- `coreBusy` = 1 for 10 cycles, CTRL = 2, then addr 15 = 0xDEADBEEF while pending → STATUS = 0x3; no pulse until busy drops; pulse one cycle later with `inputMsg`[407:376] = 0xDEADBEEF.
- Addr 3 = 0xAABBCCDD, CTRL = 3 → `inputMsg`[23:0] = 0xAABBCC; `newMsg` and `newTarget` pulse in the same cycle.
- `coreDone` with `validBTC` = 1 and `SHAoutput`[255:224] = 0x00000ABC → STATUS bit2 = 1 and addr 31 reads 0x00000ABC. Then CTRL = 4 coinciding with another valid `coreDone` → found remains 1.
